tracker_policy: RTL
===================

# tracker_policy

Parametrised line-tracker policy block. It takes an N-channel reflective sensor bar and produces the 3-bit drive command consumed by the motor controller. It adds three things: input synchronisation, per-vector debouncing, and weighted-error steering with straight / turn / sharp-turn levels. On line loss it runs a timed search in the last known direction before stopping.

## Interface
- `N_SENSORS`, 5: number of sensors. Must be odd and ≥3. `sensor[N_SENSORS-1]` is leftmost, `sensor[0]` is rightmost, centre index C=(N_SENSORS-1)/2.
- `DEBOUNCE_CYCLES`, 2: consecutive identical synchronised samples required before a vector is accepted. Must be ≥1.
- `SHARP_TH`, 2: |err| strictly above this selects a sharp turn.
- `LOST_TIMEOUT`, 4: cycles spent in a search command after line loss. Must be ≥1.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low. `reset==0` at a clk edge resets the block.
- `sensor` input N_SENSORS: raw asynchronous sensor bits, 1 = line under sensor.
- `state` output 3: drive command. Encodings: 000 turn_left, 001 turn_right, 010 go_straight, 011 stop, 100 sharp_left, 101 sharp_right, 110 search_left, 111 search_right.
- `lost` output 1: high while the filtered vector is all-zero.
- `state_chg` output 1: one-cycle pulse on the cycle `state` takes a value different from its previous one.

## Operation
- Sync: two-flop synchroniser per bit, sync1 → sync2.
- Debounce:
  - Hold a candidate vector and a saturating counter.
  - If sync2 ≠ candidate: candidate ← sync2, cnt ← 1.
  - Otherwise cnt increments, saturating at DEBOUNCE_CYCLES.
  - When cnt==DEBOUNCE_CYCLES and candidate ≠ filtered: filtered ← candidate.
- Error: err = Σ over set bits of (i − C), signed. Internal width is $clog2(N_SENSORS*N_SENSORS)+1 bits, with no overflow possible.
- Decision on filtered ≠ 0:
  - err==0 → go_straight. This includes all-ones (crossbar).
  - 0<err≤SHARP_TH → turn_left.
  - err>SHARP_TH → sharp_left.
  - Negative err mirrors to turn_right / sharp_right.
- Direction memory: last_dir ∈ {none, left, right}.
  - Updated whenever filtered ≠ 0 and err ≠ 0.
  - err==0 leaves it unchanged.
  - Reset value is none.
- Lost handling, when filtered==0:
  - On the first such cycle, load timer ← LOST_TIMEOUT and set `state` to search_left or search_right according to last_dir.
  - Hold that search command while timer>0, decrementing each cycle.
  - At timer==0, `state` becomes stop and stays there.
  - If last_dir==none, go to stop immediately.
- Recovery: filtered ≠ 0 during search or stop resumes the normal decision on the next edge. The timer is abandoned.
- Reset values: `state`=011 (stop), `lost`=0, `state_chg`=0, sync/candidate/filtered=0, cnt=0, timer=0, last_dir=none.
- Reset asserted mid-search or mid-debounce: all of the above apply at that edge, and no `state_chg` pulse is generated.

## Timing
- Latency: a sensor vector first present at edge t0 and held steady appears on `state` after edge t0+DEBOUNCE_CYCLES+3. This is 5 edges for the defaults.
- Glitch rejection: any vector held fewer than DEBOUNCE_CYCLES consecutive sync2 samples never reaches filtered.
- `lost` and the first search command become valid on the same edge, one edge after filtered goes to 0.
- Search lasts exactly LOST_TIMEOUT cycles, then stop.
- `state`, `lost` and `state_chg` are all registered. There are no combinational paths from `sensor` to any output.
- `state_chg` is high for exactly the cycle in which the new `state` value is first visible.

## Configuration
- `TRACKER_SEARCH_EN` defined: lost handling as described above, using search_left / search_right for LOST_TIMEOUT cycles.
- Undefined:
  - filtered==0 produces stop on the next edge.
  - The timer and last_dir are not built.
  - Codes 110 and 111 are never emitted.
  - `lost` still behaves as specified.

## Test plan
Defaults N=5, D=2, TH=2, TIMEOUT=4, macro defined.
- Reset: hold `reset`=0 for 3 edges with sensor=5'b11111 → `state`=011, `lost`=0, `state_chg`=0. Release, sensor=5'b00100 → `state`=010 after edge t0+5, with a single `state_chg` pulse.
- Steering:
  - 5'b01000 (err=+1) → 000.
  - 5'b11000 (err=+3) → 100.
  - 5'b00011 (err=−3) → 101.
  - 5'b00010 (err=−1) → 001.
- Crossbar: 5'b11111 → 010. last_dir is unchanged, so a following loss searches in the prior direction.
- Glitch: steady 5'b00100, then 5'b10000 for exactly 1 cycle → `state` stays 010, `state_chg` never pulses.
- Lost: from 5'b01000 to 5'b00000 → `lost`=1, `state`=110 for exactly 4 cycles, then 011. Reapplying 5'b00100 mid-search → 010 after t0+5, `lost`=0. With the macro undefined, the same loss → 011 directly.
- Reset mid-search: `reset`=0 during the 2nd search cycle → `state`=011 at that edge, `lost`=0. After release with sensor=0, `state` stays 011 (last_dir=none).

Source files
------------

// File: rtl/tracker_policy_if.sv
// Sensor bar in, drive command out, between the sensor front end and the tracker policy.
interface tracker_policy_if #(
    parameter int N_SENSORS = 5
);
    logic [N_SENSORS-1:0] sensor;
    logic [2:0]           state;
    logic                 lost;
    logic                 state_chg;

    modport master (output sensor, input state, lost, state_chg);
    modport slave  (input sensor, output state, lost, state_chg);
endinterface

// File: rtl/tracker_policy.sv
// Line-tracker policy: sync, debounce, weighted-error steering, timed search on line loss.
// Optional macro TRACKER_SEARCH_EN enables the search-on-loss behaviour (timer + last_dir).
module tracker_policy #(
    parameter int N_SENSORS       = 5,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int SHARP_TH        = 2,
    parameter int LOST_TIMEOUT    = 4
) (
    input  logic             clk,
    input  logic             reset,
    tracker_policy_if.slave  bus
);
    localparam int C     = (N_SENSORS - 1) / 2;
    localparam int ERR_W = $clog2(N_SENSORS * N_SENSORS) + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic signed [ERR_W-1:0] TH_P    = ERR_W'(SHARP_TH);
    localparam logic signed [ERR_W-1:0] TH_N    = ERR_W'(-SHARP_TH);

    typedef enum logic [2:0] {
        TURN_L   = 3'b000,
        TURN_R   = 3'b001,
        STRAIGHT = 3'b010,
        STOP     = 3'b011,
        SHARP_L  = 3'b100,
        SHARP_R  = 3'b101,
        SEARCH_L = 3'b110,
        SEARCH_R = 3'b111
    } cmd_t;

    logic [N_SENSORS-1:0]    sync1, sync2, cand, filt;
    logic [CNT_W-1:0]        cnt;
    logic signed [ERR_W-1:0] err;
    cmd_t                    state_q, track_cmd, nxt_state;
    logic                    lost_q, chg_q;

`ifdef TRACKER_SEARCH_EN
    localparam int TMR_W = $clog2(LOST_TIMEOUT + 1);
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
    logic [TMR_W-1:0] timer, nxt_timer;
    dir_t             last_dir, nxt_dir;
`endif

    // Left-of-centre sensors pull err positive, right-of-centre negative.
    always_comb begin
        err = '0;
        for (int i = 0; i < N_SENSORS; i++)
            if (filt[i]) err = err + ERR_W'(i - C);
    end

    always_comb begin
        if (err == '0)       track_cmd = STRAIGHT;
        else if (err > TH_P) track_cmd = SHARP_L;
        else if (err > 0)    track_cmd = TURN_L;
        else if (err < TH_N) track_cmd = SHARP_R;
        else                 track_cmd = TURN_R;
    end

    always_comb begin
        nxt_state = state_q;
`ifdef TRACKER_SEARCH_EN
        nxt_timer = timer;
        nxt_dir   = last_dir;
`endif
        if (filt != '0) begin
            nxt_state = track_cmd;
`ifdef TRACKER_SEARCH_EN
            nxt_timer = '0;
            if (err > 0)      nxt_dir = DIR_LEFT;
            else if (err < 0) nxt_dir = DIR_RIGHT;
`endif
        end else begin
`ifdef TRACKER_SEARCH_EN
            // lost_q low here means this is the first cycle of the loss.
            if (!lost_q) begin
                if (last_dir == DIR_LEFT) begin
                    nxt_state = SEARCH_L;
                    nxt_timer = TMR_W'(LOST_TIMEOUT);
                end else if (last_dir == DIR_RIGHT) begin
                    nxt_state = SEARCH_R;
                    nxt_timer = TMR_W'(LOST_TIMEOUT);
                end else begin
                    nxt_state = STOP;
                end
            end else if (timer != '0) begin
                nxt_timer = timer - TMR_W'(1);
                if (timer == TMR_W'(1)) nxt_state = STOP;
            end else begin
                nxt_state = STOP;
            end
`else
            nxt_state = STOP;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            filt     <= '0;
            cnt      <= '0;
            state_q  <= STOP;
            lost_q   <= 1'b0;
            chg_q    <= 1'b0;
`ifdef TRACKER_SEARCH_EN
            timer    <= '0;
            last_dir <= DIR_NONE;
`endif
        end else begin
            sync1 <= bus.sensor;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt == CNT_MAX && cand != filt) filt <= cand;
            state_q <= nxt_state;
            chg_q   <= (nxt_state != state_q);
            lost_q  <= (filt == '0);
`ifdef TRACKER_SEARCH_EN
            timer    <= nxt_timer;
            last_dir <= nxt_dir;
`endif
        end
    end

    assign bus.state     = state_q;
    assign bus.lost      = lost_q;
    assign bus.state_chg = chg_q;
endmodule
